// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// The master modport is the fetch side and the slave modport is the memory side.
interface fetch_stage_if;
  logic [31:0] imem_address;
  logic        imem_valid;
  logic        imem_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_address, imem_valid,
    input  imem_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_address, imem_valid,
    output imem_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the pc, keeps one imem request outstanding, presents words to decode.
// Optional FETCH_BYPASS_EN: issue the next request while a response is being accepted (1 instr/cycle).
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        imem,
  input  logic                 branch,
  input  logic [31:0]          branch_target,
  input  logic                 trap,
  input  logic [31:0]          trap_target,
  input  logic                 stall,
  input  logic                 invalidate,
  output logic [31:0]          pc_out,
  output logic [31:0]          next_pc_out,
  output logic [31:0]          instruction_out,
  output logic                 valid_out
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, req_pc, hold_pc, hold_data;
  logic        discard;

  logic        redirect;
  logic [31:0] target;
  logic        rsp_live;
  logic        bypass_req;
  logic        req_valid;
  logic        transfer;
  logic        capture;

  // Control decode; rsp_live marks a response that will actually be kept.
  always_comb begin
    redirect = trap | branch;
    target   = trap ? trap_target : branch_target;
    rsp_live = (state == WAIT) && imem.imem_rsp_valid && !discard && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass_req = rsp_live && !stall;
`else
    bypass_req = 1'b0;
`endif
    req_valid = ((state == ISSUE) && !redirect) || bypass_req;
    transfer  = req_valid && imem.imem_ready;
    capture   = !stall && (rsp_live || ((state == HOLD) && !redirect));
  end

  assign imem.imem_valid   = req_valid;
  assign imem.imem_address = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= ISSUE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ISSUE: if (transfer) state_next = WAIT;
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (discard || redirect) state_next = ISSUE;
          else if (stall)          state_next = HOLD;
          else if (transfer)       state_next = WAIT;
          else                     state_next = ISSUE;
        end
      end
      HOLD: if (redirect || !stall) state_next = ISSUE;
      default: state_next = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_VECTOR;
      req_pc          <= '0;
      discard         <= 1'b0;
      hold_pc         <= '0;
      hold_data       <= '0;
      pc_out          <= '0;
      next_pc_out     <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else begin
      if (redirect)      pc <= target;
      else if (transfer) pc <= pc + 32'd4;

      if (transfer) req_pc <= pc;

      // A redirect with no response this cycle leaves a wrong-path request in flight.
      if (state == WAIT) begin
        if (imem.imem_rsp_valid) discard <= 1'b0;
        else if (redirect)       discard <= 1'b1;
      end

      if (rsp_live && stall) begin
        hold_pc   <= req_pc;
        hold_data <= imem.imem_rsp_data;
      end

      if (capture) begin
        pc_out          <= (state == HOLD) ? hold_pc : req_pc;
        next_pc_out     <= ((state == HOLD) ? hold_pc : req_pc) + 32'd4;
        instruction_out <= (state == HOLD) ? hold_data : imem.imem_rsp_data;
      end

      if (redirect)    valid_out <= 1'b0;
      else if (!stall) valid_out <= capture && !invalidate;
    end
  end

endmodule
